// File: rtl/sound_pkg.sv
// Shared widths, constants and types for the tone channels of the sound generator.
package sound_pkg;

    localparam int unsigned PERIOD_W  = 16;
    localparam int unsigned VOL_W     = 5;
    localparam int unsigned WIDTH_W   = 3;
    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned AMP_SHIFT = 16;
    localparam int unsigned PROD_W    = PERIOD_W + WIDTH_W;

    typedef logic [PERIOD_W-1:0] period_t;
    typedef logic [VOL_W-1:0]    vol_t;
    typedef logic [WIDTH_W-1:0]  width_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam period_t IDLE_PERIOD = '0;

    // 31 << 16 keeps the four-channel sum inside 24-bit signed range
    function automatic sample_t vol_to_amp(input vol_t v);
        return sample_t'(v) << AMP_SHIFT;
    endfunction

endpackage

// File: rtl/sound_duty_thr.sv
// Combinational duty threshold: period * (width + 1) / 8, truncated to the period width.
module sound_duty_thr
    import sound_pkg::*;
(
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH_W-1:0]  width,
    output logic [PERIOD_W-1:0] thr
);

    logic [WIDTH_W:0]  mult;
    logic [PROD_W-1:0] prod;

    always_comb begin
        mult = {1'b0, width} + (WIDTH_W + 1)'(1);
        prod = PROD_W'(period) * PROD_W'(mult);
        thr  = period_t'(prod >> WIDTH_W);
    end

endmodule

// File: rtl/sound_channel.sv
// Square/pulse tone channel producing a registered signed 24-bit sample.
// Optional macro SOUND_CHANNEL_VOL_RAMP_EN: volume slews by one step per period wrap.
module sound_channel
    import sound_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [PERIOD_W-1:0] period,
    input  logic [VOL_W-1:0]    volume,
    input  logic [WIDTH_W-1:0]  width,
    output logic [SAMPLE_W-1:0] sample
);

    period_t period_q;
    period_t counter;
    width_t  width_q;
    period_t thr;
    sample_t amp;
    logic    idle;
    logic    wrap;

    sound_duty_thr u_thr (
        .period (period_q),
        .width  (width_q),
        .thr    (thr)
    );

    always_comb begin
        idle = (period_q == IDLE_PERIOD);
        wrap = (counter == period_q - period_t'(1));
    end

`ifdef SOUND_CHANNEL_VOL_RAMP_EN
    vol_t vol_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vol_q <= '0;
        end else if (idle) begin
            vol_q <= '0;
        end else if (wrap) begin
            if (vol_q < volume)
                vol_q <= vol_q + vol_t'(1);
            else if (vol_q > volume)
                vol_q <= vol_q - vol_t'(1);
        end
    end

    always_comb amp = vol_to_amp(vol_q);
`else
    always_comb amp = vol_to_amp(volume);
`endif

    // period/width are only sampled while idle or at a wrap, so tone changes stay glitch-free
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_q <= '0;
            width_q  <= '0;
            counter  <= '0;
            sample   <= '0;
        end else if (idle) begin
            period_q <= period;
            width_q  <= width;
            counter  <= '0;
            sample   <= '0;
        end else begin
            sample <= (counter < thr) ? amp : -amp;
            if (wrap) begin
                counter  <= '0;
                period_q <= period;
                width_q  <= width;
            end else begin
                counter <= counter + period_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_sound_channel.sv
// Directed self-checking bench for sound_channel.
module tb_sound_channel;

    logic        clk;
    logic        resetn;
    logic [15:0] period;
    logic [4:0]  volume;
    logic [2:0]  width;
    logic [23:0] sample;

    int total;
    int bad;

    sound_channel dut (
        .clk    (clk),
        .resetn (resetn),
        .period (period),
        .volume (volume),
        .width  (width),
        .sample (sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the channel loaded; the next edge processes counter 0.
    task automatic do_reset(input logic [15:0] p, input logic [2:0] w, input logic [4:0] v);
        resetn = 1'b0;
        period = p;
        width  = w;
        volume = v;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [23:0] exp;
        resetn = 1'b0;
        period = 16'd8;
        width  = 3'd3;
        volume = 5'd4;
        tick();
        tick();
        total++;
        if (sample !== 24'h000000) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", sample, 24'h000000);
        end
        resetn = 1'b1;
        tick();
        total++;
        if (sample !== 24'h000000) begin
            bad++;
            $display("FAIL load_cycle got=%h want=%h", sample, 24'h000000);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = (i % 8 < 4) ? 24'h040000 : 24'hFC0000;
            total++;
            if (sample !== exp) begin
                bad++;
                $display("FAIL pattern_w3_v4[%0d] got=%h want=%h", i, sample, exp);
            end
        end
    endtask

    task automatic test_duty();
        logic [23:0] exp;
        do_reset(16'd8, 3'd0, 5'd31);
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = (i % 8 == 0) ? 24'h1F0000 : 24'hE10000;
            total++;
            if (sample !== exp) begin
                bad++;
                $display("FAIL duty_w0[%0d] got=%h want=%h", i, sample, exp);
            end
        end
        do_reset(16'd8, 3'd7, 5'd31);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (sample !== 24'h1F0000) begin
                bad++;
                $display("FAIL duty_w7[%0d] got=%h want=%h", i, sample, 24'h1F0000);
            end
        end
        do_reset(16'd1, 3'd3, 5'd31);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (sample !== 24'hE10000) begin
                bad++;
                $display("FAIL period1[%0d] got=%h want=%h", i, sample, 24'hE10000);
            end
        end
        do_reset(16'd8, 3'd3, 5'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (sample !== 24'h000000) begin
                bad++;
                $display("FAIL vol0[%0d] got=%h want=%h", i, sample, 24'h000000);
            end
        end
    endtask

    task automatic test_period_change();
        logic [23:0] exp_old [5] = '{24'h040000, 24'hFC0000, 24'hFC0000, 24'hFC0000, 24'hFC0000};
        logic [23:0] exp_vol [4] = '{24'h020000, 24'h020000, 24'hFE0000, 24'hFE0000};
        logic [23:0] exp;
        do_reset(16'd8, 3'd3, 5'd4);
        tick();
        tick();
        tick();
        period = 16'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (sample !== exp_old[i]) begin
                bad++;
                $display("FAIL old_period_tail[%0d] got=%h want=%h", i, sample, exp_old[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (i % 4 < 2) ? 24'h040000 : 24'hFC0000;
            total++;
            if (sample !== exp) begin
                bad++;
                $display("FAIL new_period4[%0d] got=%h want=%h", i, sample, exp);
            end
        end
        volume = 5'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (sample !== exp_vol[i]) begin
                bad++;
                $display("FAIL vol_change[%0d] got=%h want=%h", i, sample, exp_vol[i]);
            end
        end
    endtask

    task automatic test_period_zero();
        logic [23:0] exp_tail [6] = '{24'h040000, 24'h040000, 24'hFC0000, 24'hFC0000, 24'hFC0000, 24'hFC0000};
        logic [23:0] exp;
        do_reset(16'd8, 3'd3, 5'd4);
        tick();
        tick();
        period = 16'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (sample !== exp_tail[i]) begin
                bad++;
                $display("FAIL stop_tail[%0d] got=%h want=%h", i, sample, exp_tail[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (sample !== 24'h000000) begin
                bad++;
                $display("FAIL idle[%0d] got=%h want=%h", i, sample, 24'h000000);
            end
        end
        period = 16'd8;
        tick();
        total++;
        if (sample !== 24'h000000) begin
            bad++;
            $display("FAIL restart_load got=%h want=%h", sample, 24'h000000);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (i < 4) ? 24'h040000 : 24'hFC0000;
            total++;
            if (sample !== exp) begin
                bad++;
                $display("FAIL restart[%0d] got=%h want=%h", i, sample, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(16'd8, 3'd3, 5'd4);
        tick();
        tick();
        total++;
        if (sample !== 24'h040000) begin
            bad++;
            $display("FAIL pre_async got=%h want=%h", sample, 24'h040000);
        end
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (sample !== 24'h000000) begin
            bad++;
            $display("FAIL async_clear got=%h want=%h", sample, 24'h000000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (sample !== 24'h000000) begin
                bad++;
                $display("FAIL reset_low[%0d] got=%h want=%h", i, sample, 24'h000000);
            end
        end
        resetn = 1'b1;
        tick();
        total++;
        if (sample !== 24'h000000) begin
            bad++;
            $display("FAIL post_reset_load got=%h want=%h", sample, 24'h000000);
        end
        tick();
        total++;
        if (sample !== 24'h040000) begin
            bad++;
            $display("FAIL post_reset_first got=%h want=%h", sample, 24'h040000);
        end
    endtask

`ifdef SOUND_CHANNEL_VOL_RAMP_EN
    task automatic test_vol_ramp();
        logic [23:0] amp_hi [5] = '{24'h000000, 24'h010000, 24'h020000, 24'h030000, 24'h030000};
        logic [23:0] amp_lo [5] = '{24'h000000, 24'hFF0000, 24'hFE0000, 24'hFD0000, 24'hFD0000};
        logic [23:0] exp;
        do_reset(16'd4, 3'd3, 5'd0);
        volume = 5'd3;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                exp = (i < 2) ? amp_hi[p] : amp_lo[p];
                total++;
                if (sample !== exp) begin
                    bad++;
                    $display("FAIL ramp[%0d][%0d] got=%h want=%h", p, i, sample, exp);
                end
            end
        end
    endtask
`endif

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        period = '0;
        width  = '0;
        volume = '0;
`ifdef SOUND_CHANNEL_VOL_RAMP_EN
        test_vol_ramp();
`else
        test_reset();
        test_duty();
        test_period_change();
        test_period_zero();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
